// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin arbiter for three requesters (a, b, c) sharing
// one mux path. Each tenure is bounded to MAX_HOLD cycles while others wait.
// gnt, owner and the mux selects are all registered, so the path only
// switches on a clock edge.
module mux_sel_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic [1:0] owner,
    output logic       busy,
    output logic       sel_1,
    output logic       sel_2
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

    state_t     state;
    state_t     next_state;
    logic [1:0] last;
    logic [1:0] next_last;
    logic [3:0] hold_cnt;
    logic [3:0] next_hold;
    logic [1:0] next_owner;
    logic [2:0] others;
    logic [2:0] pick_res;

    // Returns the request bit for a requester index.
    // Index 3 never occurs; it aliases to c.
    function automatic logic req_bit(input logic [2:0] mask, input logic [1:0] idx);
        case (idx)
            2'd0:    req_bit = mask[0];
            2'd1:    req_bit = mask[1];
            default: req_bit = mask[2];
        endcase
    endfunction

    // Steps the round-robin pointer to the next requester index (mod 3).
    function automatic logic [1:0] rr_next(input logic [1:0] p);
        rr_next = (p >= 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Round-robin pick: finds the first set bit scanning p+1, p+2, then p.
    // The result is {found, index}.
    function automatic logic [2:0] rr_pick(input logic [2:0] mask, input logic [1:0] p);
        logic [1:0] c0;
        logic [1:0] c1;
        c0 = rr_next(p);
        c1 = rr_next(c0);
        if (req_bit(mask, c0))
            rr_pick = {1'b1, c0};
        else if (req_bit(mask, c1))
            rr_pick = {1'b1, c1};
        else if (req_bit(mask, p))
            rr_pick = {1'b1, p};
        else
            rr_pick = 3'b000;
    endfunction

    // Converts a requester index to its one-hot grant pattern.
    function automatic logic [2:0] one_hot(input logic [1:0] idx);
        case (idx)
            2'd0:    one_hot = 3'b001;
            2'd1:    one_hot = 3'b010;
            default: one_hot = 3'b100;
        endcase
    endfunction

    // Decides the next state: release handoff takes priority over preemption,
    // and preemption over extending the tenure.
    always_comb begin
        next_state = state;
        next_last  = last;
        next_hold  = hold_cnt;
        next_owner = owner;
        others     = req & ~one_hot(owner);
        pick_res   = 3'b000;
        case (state)
            IDLE: begin
                if (req != 3'b000) begin
                    pick_res   = rr_pick(req, last);
                    next_state = GRANT;
                    next_owner = pick_res[1:0];
                    next_hold  = 4'd1;
                end
            end
            GRANT: begin
                if (!req_bit(req, owner)) begin
                    pick_res  = rr_pick(others, owner);
                    next_last = owner;
                    if (pick_res[2]) begin
                        next_owner = pick_res[1:0];
                        next_hold  = 4'd1;
                    end else begin
                        next_state = IDLE;
                        next_hold  = 4'd0;
                    end
                end else if (hold_cnt == HOLD_LIMIT && others != 3'b000) begin
                    pick_res   = rr_pick(others, owner);
                    next_last  = owner;
                    next_owner = pick_res[1:0];
                    next_hold  = 4'd1;
                end else if (hold_cnt == HOLD_LIMIT) begin
                    next_hold = 4'd1;
                end else begin
                    next_hold = hold_cnt + 4'd1;
                end
            end
            default: begin
                next_state = IDLE;
                next_hold  = 4'd0;
            end
        endcase
    end

    // Registers the arbitration state together with the grant and the mux
    // selects. The selects keep the last owner while idle, so the mux never
    // floats.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 2'd2;
            hold_cnt <= 4'd0;
            gnt      <= 3'b000;
            owner    <= 2'd0;
            sel_1    <= 1'b0;
            sel_2    <= 1'b0;
        end else begin
            state    <= next_state;
            last     <= next_last;
            hold_cnt <= next_hold;
            owner    <= next_owner;
            gnt      <= (next_state == GRANT) ? one_hot(next_owner) : 3'b000;
            sel_1    <= (next_owner == 2'd1);
            sel_2    <= (next_owner == 2'd2);
        end
    end

    assign busy = |gnt;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter: directed self-checking bench for mux_sel_arbiter.
// dut runs with the default MAX_HOLD=4 and dut1 runs with MAX_HOLD=1.
module tb_mux_sel_arbiter;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [2:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       sel_1;
    logic       sel_2;

    logic [2:0] req1;
    logic [2:0] gnt1;
    logic [1:0] owner1;
    logic       busy1;
    logic       sel1_1;
    logic       sel1_2;

    int checks;
    int failures;

    mux_sel_arbiter #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .gnt   (gnt),
        .owner (owner),
        .busy  (busy),
        .sel_1 (sel_1),
        .sel_2 (sel_2)
    );

    mux_sel_arbiter #(.MAX_HOLD(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .req   (req1),
        .gnt   (gnt1),
        .owner (owner1),
        .busy  (busy1),
        .sel_1 (sel1_1),
        .sel_2 (sel1_2)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stops a runaway simulation.
    initial begin
        #20000;
        $display("[TB] FAIL timeout: got no finish, expected finish before 20000");
        $fatal(1, "[TB] timeout");
    end

    // Counts one comparison and reports it when the values differ.
    task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Checks all outputs of the MAX_HOLD=4 instance.
    // sel is given as {sel_1, sel_2}.
    task automatic checkArb(input string tag, input logic [2:0] eg, input logic [1:0] eo,
                            input logic [1:0] es);
        checkOutput({tag, "_gnt"},   {1'b0, gnt},   {1'b0, eg});
        checkOutput({tag, "_owner"}, {2'b0, owner}, {2'b0, eo});
        checkOutput({tag, "_busy"},  {3'b0, busy},  {3'b0, |eg});
        checkOutput({tag, "_sel"},   {2'b0, sel_1, sel_2}, {2'b0, es});
    endtask

    // Checks all outputs of the MAX_HOLD=1 instance.
    task automatic checkArb1(input string tag, input logic [2:0] eg, input logic [1:0] eo,
                             input logic [1:0] es);
        checkOutput({tag, "_gnt"},   {1'b0, gnt1},   {1'b0, eg});
        checkOutput({tag, "_owner"}, {2'b0, owner1}, {2'b0, eo});
        checkOutput({tag, "_busy"},  {3'b0, busy1},  {3'b0, |eg});
        checkOutput({tag, "_sel"},   {2'b0, sel1_1, sel1_2}, {2'b0, es});
    endtask

    // Advances one active edge and waits until the falling edge, where the
    // outputs are sampled and new inputs are driven.
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req      = 3'b111;
        req1     = 3'b000;

        // Reset is held for two edges with every source requesting.
        applyStimulus(1);
        checkArb("reset_1", 3'b000, 2'd0, 2'b00);
        applyStimulus(1);
        checkArb("reset_2", 3'b000, 2'd0, 2'b00);
        checkArb1("reset_mh1", 3'b000, 2'd0, 2'b00);

        // Full contention: tenures of a, b, c, then a, four cycles each.
        rst = 1'b0;
        applyStimulus(1);
        checkArb("first_a", 3'b001, 2'd0, 2'b00);
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1);
            case ((i / 4) % 3)
                0:       checkArb($sformatf("rr_%0d", i), 3'b001, 2'd0, 2'b00);
                1:       checkArb($sformatf("rr_%0d", i), 3'b010, 2'd1, 2'b10);
                default: checkArb($sformatf("rr_%0d", i), 3'b100, 2'd2, 2'b01);
            endcase
        end

        // Mid-tenure reset during b's tenure; after it a wins, not c.
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
        req = 3'b111;
        applyStimulus(4);
        checkArb("mid_a4", 3'b001, 2'd0, 2'b00);
        applyStimulus(1);
        checkArb("mid_b1", 3'b010, 2'd1, 2'b10);
        applyStimulus(1);
        checkArb("mid_b2", 3'b010, 2'd1, 2'b10);
        rst = 1'b1;
        applyStimulus(1);
        checkArb("mid_rst", 3'b000, 2'd0, 2'b00);
        rst = 1'b0;
        applyStimulus(1);
        checkArb("mid_after", 3'b001, 2'd0, 2'b00);

        // Single requester c keeps the grant with no gaps.
        // The selects stay 0/1 after release.
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
        req = 3'b100;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1);
            checkArb($sformatf("single_c_%0d", i), 3'b100, 2'd2, 2'b01);
        end
        req = 3'b000;
        applyStimulus(1);
        checkArb("single_rel", 3'b000, 2'd2, 2'b01);
        applyStimulus(1);
        checkArb("single_idle", 3'b000, 2'd2, 2'b01);

        // Early release handoff from b to c with no idle bubble.
        // c then holds for the full four cycles.
        req = 3'b010;
        applyStimulus(1);
        checkArb("hand_b", 3'b010, 2'd1, 2'b10);
        req = 3'b101;
        applyStimulus(1);
        checkArb("hand_c1", 3'b100, 2'd2, 2'b01);
        applyStimulus(3);
        checkArb("hand_c4", 3'b100, 2'd2, 2'b01);
        applyStimulus(1);
        checkArb("hand_a", 3'b001, 2'd0, 2'b00);
        req = 3'b000;
        applyStimulus(1);
        checkArb("hand_idle", 3'b000, 2'd0, 2'b00);

        // MAX_HOLD=1 with a and b requesting rotates the grant every cycle.
        req1 = 3'b011;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1);
            if (i % 2 == 0)
                checkArb1($sformatf("mh1_%0d", i), 3'b001, 2'd0, 2'b00);
            else
                checkArb1($sformatf("mh1_%0d", i), 3'b010, 2'd1, 2'b10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
